button_event_gen: RTL and testbench

Consumes the clean, debounced button level on the pixel/system clock and turns it into discrete user events: PRESS, RELEASE, LONG and REPEAT. Events are queued in a 2-entry FIFO and presented on a valid/ready interface. The main consumer is the camera register-config sequencer, which uses the events to step through mode and brightness settings. The block sits directly downstream of the switch debouncer.

---
 rtl/button_event_gen.sv | 183 ++++++++++++++++++
 tb/tb_button_event_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// Button event generator: turns a debounced button level into PRESS / RELEASE / LONG / REPEAT
// events, queued in a 2-entry FIFO with a valid/ready head and a sticky overflow flag.
// Optional feature macro: BUTTON_EVT_REPEAT_EN (when undefined, HELD only waits for release
// and REPEAT is never produced).
module button_event_gen #(
    parameter int unsigned c_LONG_PRESS    = 50000000,
    parameter int unsigned c_REPEAT_PERIOD = 10000000,
    parameter int unsigned c_CNT_WIDTH     = 26
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch,
    output logic       o_Evt_Valid,
    output logic [1:0] o_Evt_Code,
    input  logic       i_Evt_Ready,
    output logic       o_Overflow,
    input  logic       i_Ovf_Clr,
    output logic       o_Held
);

    localparam logic [1:0] EvtPress   = 2'b00;
    localparam logic [1:0] EvtRelease = 2'b01;
    localparam logic [1:0] EvtLong    = 2'b10;

    localparam logic [c_CNT_WIDTH-1:0] LongTerm = c_CNT_WIDTH'(c_LONG_PRESS - 1);

`ifdef BUTTON_EVT_REPEAT_EN
    localparam logic [1:0]             EvtRepeat = 2'b11;
    localparam logic [c_CNT_WIDTH-1:0] RepTerm   = c_CNT_WIDTH'(c_REPEAT_PERIOD - 1);
`else
    // Repeat period has no effect in this build.
    logic unused_repeat_period;
    assign unused_repeat_period = ^c_REPEAT_PERIOD;
`endif

    typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

    state_e                 state_q, state_d;
    logic [c_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   sw_prev_q;
    logic                   held_q;
    logic                   rise, fall;
    logic                   push;
    logic [1:0]             push_code;

    logic [1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic [1:0] fifo_cnt_q, fifo_cnt_d, fifo_cnt_mid;
    logic       valid_q;
    logic       ovf_q, ovf_d;
    logic       pop, drop;

    assign rise = i_Switch & ~sw_prev_q;
    assign fall = ~i_Switch & sw_prev_q;

    // Button FSM: decides next state, counter value and the single event pushed this cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_code = EvtPress;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    push      = 1'b1;
                    push_code = EvtPress;
                    cnt_d     = '0;
                    state_d   = StPressed;
                end
            end
            StPressed: begin
                // Release beats a terminal count landing on the same cycle.
                if (fall) begin
                    push      = 1'b1;
                    push_code = EvtRelease;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else if (cnt_q == LongTerm) begin
                    push      = 1'b1;
                    push_code = EvtLong;
                    cnt_d     = '0;
                    state_d   = StHeld;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (fall) begin
                    push      = 1'b1;
                    push_code = EvtRelease;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end
`ifdef BUTTON_EVT_REPEAT_EN
                else if (cnt_q == RepTerm) begin
                    push      = 1'b1;
                    push_code = EvtRepeat;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, hold counter, edge-detect history and held flag.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sw_prev_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sw_prev_q <= i_Switch;
            held_q    <= (state_d != StIdle);
        end
    end

    assign pop = valid_q & i_Evt_Ready;

    // FIFO next state: pop shifts slot 1 down, then a push lands in the first free slot.
    always_comb begin
        mem0_d       = mem0_q;
        mem1_d       = mem1_q;
        fifo_cnt_mid = fifo_cnt_q;
        drop         = 1'b0;
        if (pop) begin
            mem0_d       = mem1_q;
            mem1_d       = EvtPress;
            fifo_cnt_mid = fifo_cnt_q - 2'd1;
        end
        fifo_cnt_d = fifo_cnt_mid;
        if (push) begin
            if (fifo_cnt_mid == 2'd2) begin
                drop = 1'b1;
            end else begin
                if (fifo_cnt_mid == 2'd0) begin
                    mem0_d = push_code;
                end else begin
                    mem1_d = push_code;
                end
                fifo_cnt_d = fifo_cnt_mid + 2'd1;
            end
        end
        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_Ovf_Clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO storage, occupancy, head-valid and overflow registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            mem0_q     <= EvtPress;
            mem1_q     <= EvtPress;
            fifo_cnt_q <= 2'd0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            mem0_q     <= mem0_d;
            mem1_q     <= mem1_d;
            fifo_cnt_q <= fifo_cnt_d;
            valid_q    <= (fifo_cnt_d != 2'd0);
            ovf_q      <= ovf_d;
        end
    end

    assign o_Evt_Valid = valid_q;
    assign o_Evt_Code  = mem0_q;
    assign o_Overflow  = ovf_q;
    assign o_Held      = held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen (c_LONG_PRESS=8, c_REPEAT_PERIOD=4).
// Expectations adapt to BUTTON_EVT_REPEAT_EN.
module tb_button_event_gen;

    localparam int unsigned LongP = 8;
    localparam int unsigned RepP  = 4;
    localparam int unsigned CntW  = 8;
`ifdef BUTTON_EVT_REPEAT_EN
    localparam bit RepEn = 1'b1;
`else
    localparam bit RepEn = 1'b0;
`endif

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_Switch = 1'b0;
    logic       i_Evt_Ready = 1'b1;
    logic       i_Ovf_Clr = 1'b0;
    logic       o_Evt_Valid;
    logic [1:0] o_Evt_Code;
    logic       o_Overflow;
    logic       o_Held;

    int total = 0;
    int bad   = 0;

    button_event_gen #(
        .c_LONG_PRESS   (LongP),
        .c_REPEAT_PERIOD(RepP),
        .c_CNT_WIDTH    (CntW)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Switch   (i_Switch),
        .o_Evt_Valid(o_Evt_Valid),
        .o_Evt_Code (o_Evt_Code),
        .i_Evt_Ready(i_Evt_Ready),
        .o_Overflow (o_Overflow),
        .i_Ovf_Clr  (i_Ovf_Clr),
        .o_Held     (o_Held)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_code(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state, checked while reset is held and after release.
        #1;
        chk_bit("rst_valid", o_Evt_Valid, 1'b0);
        chk_code("rst_code", o_Evt_Code, 2'b00);
        chk_bit("rst_ovf", o_Overflow, 1'b0);
        chk_bit("rst_held", o_Held, 1'b0);
        step();
        i_Rst_L = 1'b1;
        step();
        chk_bit("idle_valid", o_Evt_Valid, 1'b0);
        chk_bit("idle_held", o_Held, 1'b0);

        // 1: short 3-cycle press.
        i_Switch = 1'b1;
        step();
        chk_bit("t1_press_valid", o_Evt_Valid, 1'b1);
        chk_code("t1_press_code", o_Evt_Code, 2'b00);
        chk_bit("t1_held", o_Held, 1'b1);
        step();
        chk_bit("t1_popped", o_Evt_Valid, 1'b0);
        step();
        i_Switch = 1'b0;
        step();
        chk_bit("t1_rel_valid", o_Evt_Valid, 1'b1);
        chk_code("t1_rel_code", o_Evt_Code, 2'b01);
        chk_bit("t1_rel_held", o_Held, 1'b0);
        step();
        chk_bit("t1_empty", o_Evt_Valid, 1'b0);
        chk_bit("t1_ovf", o_Overflow, 1'b0);

        // 2: long hold, LONG at +8, REPEAT at +12/+16/+20 when enabled.
        i_Switch = 1'b1;
        step();
        chk_code("t2_press_code", o_Evt_Code, 2'b00);
        for (int i = 1; i <= 22; i++) begin
            step();
            chk_bit($sformatf("t2_valid_%0d", i), o_Evt_Valid,
                    (i == 8) || (RepEn && (i == 12 || i == 16 || i == 20)));
            if (i == 8) chk_code("t2_long_code", o_Evt_Code, 2'b10);
            if (i == 12) chk_code("t2_rep_code", o_Evt_Valid ? o_Evt_Code : 2'b11, 2'b11);
        end
        chk_bit("t2_held", o_Held, 1'b1);
        i_Switch = 1'b0;
        step();
        chk_bit("t2_rel_valid", o_Evt_Valid, 1'b1);
        chk_code("t2_rel_code", o_Evt_Code, 2'b01);
        chk_bit("t2_rel_held", o_Held, 1'b0);
        step();
        chk_bit("t2_empty", o_Evt_Valid, 1'b0);

        // 3: button held through reset release.
        i_Rst_L  = 1'b0;
        i_Switch = 1'b1;
        step();
        chk_bit("t3_rst_held", o_Held, 1'b0);
        chk_bit("t3_rst_valid", o_Evt_Valid, 1'b0);
        i_Rst_L = 1'b1;
        step();
        chk_bit("t3_press_valid", o_Evt_Valid, 1'b1);
        chk_code("t3_press_code", o_Evt_Code, 2'b00);
        chk_bit("t3_held", o_Held, 1'b1);
        i_Switch = 1'b0;
        step();
        chk_bit("t3_rel_valid", o_Evt_Valid, 1'b1);
        chk_code("t3_rel_code", o_Evt_Code, 2'b01);
        step();
        chk_bit("t3_empty", o_Evt_Valid, 1'b0);

        // 4: consumer stalled; third event (RELEASE) is dropped.
        i_Evt_Ready = 1'b0;
        i_Switch    = 1'b1;
        step();
        chk_code("t4_head_press", o_Evt_Code, 2'b00);
        repeat (7) step();
        step();
        chk_bit("t4_full_valid", o_Evt_Valid, 1'b1);
        chk_code("t4_full_head", o_Evt_Code, 2'b00);
        chk_bit("t4_no_ovf_yet", o_Overflow, 1'b0);
        step();
        i_Switch = 1'b0;
        step();
        chk_bit("t4_ovf_set", o_Overflow, 1'b1);
        chk_code("t4_head_stable", o_Evt_Code, 2'b00);
        i_Evt_Ready = 1'b1;
        step();
        chk_bit("t4_second_valid", o_Evt_Valid, 1'b1);
        chk_code("t4_second_long", o_Evt_Code, 2'b10);
        step();
        chk_bit("t4_drained", o_Evt_Valid, 1'b0);
        chk_bit("t4_ovf_sticky", o_Overflow, 1'b1);
        i_Ovf_Clr = 1'b1;
        step();
        i_Ovf_Clr = 1'b0;
        chk_bit("t4_ovf_clr", o_Overflow, 1'b0);

        // 5: push into a full FIFO on the same cycle as a pop.
        i_Evt_Ready = 1'b0;
        i_Switch    = 1'b1;
        step();
        repeat (7) step();
        step();
        chk_bit("t5_full_no_ovf", o_Overflow, 1'b0);
        i_Switch    = 1'b0;
        i_Evt_Ready = 1'b1;
        step();
        chk_bit("t5_no_drop", o_Overflow, 1'b0);
        chk_code("t5_head_long", o_Evt_Code, 2'b10);
        step();
        chk_bit("t5_rel_valid", o_Evt_Valid, 1'b1);
        chk_code("t5_head_rel", o_Evt_Code, 2'b01);
        step();
        chk_bit("t5_empty", o_Evt_Valid, 1'b0);
        chk_bit("t5_ovf_final", o_Overflow, 1'b0);

        // 6a: release on the terminal-count cycle yields RELEASE only.
        i_Switch = 1'b1;
        step();
        chk_code("t6_press_code", o_Evt_Code, 2'b00);
        repeat (6) step();
        step();
        i_Switch = 1'b0;
        step();
        chk_bit("t6_rel_valid", o_Evt_Valid, 1'b1);
        chk_code("t6_rel_not_long", o_Evt_Code, 2'b01);
        chk_bit("t6_rel_held", o_Held, 1'b0);
        step();
        chk_bit("t6_no_long", o_Evt_Valid, 1'b0);

        // 6b: asynchronous reset while HELD.
        i_Evt_Ready = 1'b0;
        i_Switch    = 1'b1;
        step();
        repeat (8) step();
        chk_bit("t6_held_before", o_Held, 1'b1);
        chk_bit("t6_valid_before", o_Evt_Valid, 1'b1);
        #2;
        i_Rst_L = 1'b0;
        #1;
        chk_bit("t6_async_valid", o_Evt_Valid, 1'b0);
        chk_bit("t6_async_held", o_Held, 1'b0);
        chk_code("t6_async_code", o_Evt_Code, 2'b00);
        i_Switch = 1'b0;
        step();
        i_Rst_L = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
